// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - IF-stage bundle: instruction SRAM port, redirect inputs, IF->ID handshake
interface if_fetch_ctrl_if;
    // redirect sources
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        id_br_taken;
    logic [31:0] id_br_target;
    // ID-side handshake
    logic        id_allow_in;
    logic        if_valid;
    logic        if_ready_go;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    // instruction SRAM-like port
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  wb_ex, ex_entry, id_br_taken, id_br_target, id_allow_in,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output if_valid, if_ready_go, if_pc, if_inst,
        output inst_sram_req, inst_sram_addr
    );

    modport slave (
        output wb_ex, ex_entry, id_br_taken, id_br_target, id_allow_in,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  if_valid, if_ready_go, if_pc, if_inst,
        input  inst_sram_req, inst_sram_addr
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch controller with single outstanding request and redirect drop
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT_DATA = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        drop_q, drop_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    // run_q keeps req low until the first edge after reset release
    logic        run_q;

    logic        redir;
    logic [31:0] redir_target;
    logic        req;
    logic        addr_acc;

    assign redir        = bus.wb_ex | bus.id_br_taken;
    assign redir_target = bus.wb_ex ? bus.ex_entry : bus.id_br_target;
    assign req          = (state_q == REQ) && run_q;
    assign addr_acc     = req && bus.inst_sram_addr_ok;

    // next-state and datapath updates for the fetch FSM
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        if_pc_d       = if_pc_q;
        inst_buf_d    = inst_buf_q;
        drop_d        = drop_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            REQ: begin
                if (addr_acc) begin
                    // the issued request is stale if any redirect is pending or arriving now
                    if_pc_d       = fetch_pc_q;
                    state_d       = WAIT_DATA;
                    drop_d        = redir | redir_valid_q;
                    redir_valid_d = 1'b0;
                    if (redir) begin
                        fetch_pc_d = redir_target;
                    end else if (redir_valid_q) begin
                        fetch_pc_d = redir_pc_q;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redir) begin
                    // address must stay stable until accepted, so park the target
                    redir_valid_d = 1'b1;
                    redir_pc_d    = redir_target;
                end
            end
            WAIT_DATA: begin
                if (bus.inst_sram_data_ok) begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                    if (redir) begin
                        fetch_pc_d = redir_target;
                    end else if (!drop_q && !bus.id_allow_in) begin
                        inst_buf_d = bus.inst_sram_rdata;
                        state_d    = HOLD;
                    end
                end else if (redir) begin
                    drop_d     = 1'b1;
                    fetch_pc_d = redir_target;
                end
            end
            HOLD: begin
                if (redir) begin
                    fetch_pc_d = redir_target;
                    state_d    = REQ;
                end else if (bus.id_allow_in) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= REQ;
            fetch_pc_q    <= RESET_PC;
            if_pc_q       <= 32'd0;
            inst_buf_q    <= 32'd0;
            drop_q        <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            if_pc_q       <= if_pc_d;
            inst_buf_q    <= inst_buf_d;
            drop_q        <= drop_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            run_q         <= 1'b1;
        end
    end

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = fetch_pc_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_inst        = (state_q == HOLD) ? inst_buf_q : bus.inst_sram_rdata;
    assign bus.if_ready_go    = (state_q == HOLD) ||
                                ((state_q == WAIT_DATA) && bus.inst_sram_data_ok && !drop_q);
    assign bus.if_valid       = (((state_q == WAIT_DATA) && !drop_q) || (state_q == HOLD)) && !redir;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(.RESET_PC(32'h1C00_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.wb_ex             = 1'b0;
        bus.ex_entry          = 32'd0;
        bus.id_br_taken       = 1'b0;
        bus.id_br_target      = 32'd0;
        bus.id_allow_in       = 1'b1;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'h0BAD_0BAD;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 4; i++) begin
            if (bus.inst_sram_req) break;
            cyc();
        end
        total++;
        if (bus.inst_sram_req !== 1'b1) begin
            bad++;
            $display("FAIL %s req_timeout: got %b want 1", name, bus.inst_sram_req);
        end
    endtask

    task automatic test_reset();
        clr();
        rst = 1'b0;
        #2;
        total++;
        if (bus.inst_sram_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.inst_sram_req); end
        total++;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.if_valid); end
        total++;
        if (bus.if_pc !== 32'd0) begin bad++; $display("FAIL rst_if_pc: got %h want 0", bus.if_pc); end
        total++;
        if (bus.if_ready_go !== 1'b0) begin bad++; $display("FAIL rst_ready_go: got %b want 0", bus.if_ready_go); end
        cyc();
        cyc();
        rst = 1'b1;
        wait_req("reset");
        total++;
        if (bus.inst_sram_addr !== 32'h1C00_0000) begin bad++; $display("FAIL rst_addr: got %h want 1c000000", bus.inst_sram_addr); end
    endtask

    task automatic test_seq();
        logic [31:0] rd [3];
        logic [31:0] pc;
        rd[0] = 32'h0280_0401;
        rd[1] = 32'h0280_0802;
        rd[2] = 32'h0280_0C03;
        for (int k = 0; k < 3; k++) begin
            pc = 32'h1C00_0000 + 32'(4 * k);
            clr();
            bus.inst_sram_addr_ok = 1'b1;
            #1;
            total++;
            if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== pc) begin
                bad++; $display("FAIL seq_req%0d: got req=%b addr=%h want 1 %h", k, bus.inst_sram_req, bus.inst_sram_addr, pc);
            end
            cyc();
            clr();
            bus.inst_sram_data_ok = 1'b1;
            bus.inst_sram_rdata   = rd[k];
            #1;
            total++;
            if (bus.if_ready_go !== 1'b1 || bus.if_inst !== rd[k] || bus.if_pc !== pc || bus.if_valid !== 1'b1) begin
                bad++; $display("FAIL seq_data%0d: got rg=%b inst=%h pc=%h v=%b want 1 %h %h 1",
                                k, bus.if_ready_go, bus.if_inst, bus.if_pc, bus.if_valid, rd[k], pc);
            end
            cyc();
        end
    endtask

    task automatic test_hold();
        clr();
        bus.inst_sram_addr_ok = 1'b1;
        #1;
        total++;
        if (bus.inst_sram_addr !== 32'h1C00_000C) begin bad++; $display("FAIL hold_addr: got %h want 1c00000c", bus.inst_sram_addr); end
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'h1234_5678;
        bus.id_allow_in       = 1'b0;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b1) begin bad++; $display("FAIL hold_first_rg: got %b want 1", bus.if_ready_go); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            clr();
            bus.id_allow_in       = 1'b0;
            bus.inst_sram_rdata   = 32'hFFFF_0000 + 32'(i);
            bus.inst_sram_data_ok = (i == 1);
            #1;
            total++;
            if (bus.inst_sram_req !== 1'b0 || bus.if_ready_go !== 1'b1 || bus.if_inst !== 32'h1234_5678 || bus.if_valid !== 1'b1) begin
                bad++; $display("FAIL hold_cyc%0d: got req=%b rg=%b inst=%h v=%b want 0 1 12345678 1",
                                i, bus.inst_sram_req, bus.if_ready_go, bus.if_inst, bus.if_valid);
            end
            cyc();
        end
        clr();
        #1;
        total++;
        if (bus.if_inst !== 32'h1234_5678 || bus.if_ready_go !== 1'b1) begin
            bad++; $display("FAIL hold_release: got inst=%h rg=%b want 12345678 1", bus.if_inst, bus.if_ready_go);
        end
        cyc();
        total++;
        if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C00_0010) begin
            bad++; $display("FAIL hold_next: got req=%b addr=%h want 1 1c000010", bus.inst_sram_req, bus.inst_sram_addr);
        end
    endtask

    task automatic test_branch();
        clr();
        bus.inst_sram_addr_ok = 1'b1;
        cyc();
        clr();
        bus.id_br_taken  = 1'b1;
        bus.id_br_target = 32'h1C00_0100;
        #1;
        total++;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL br_valid_redir: got %b want 0", bus.if_valid); end
        cyc();
        clr();
        #1;
        total++;
        if (bus.if_valid !== 1'b0 || bus.inst_sram_req !== 1'b0) begin
            bad++; $display("FAIL br_wait: got v=%b req=%b want 0 0", bus.if_valid, bus.inst_sram_req);
        end
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b0) begin bad++; $display("FAIL br_drop: got rg=%b want 0", bus.if_ready_go); end
        cyc();
        clr();
        #1;
        total++;
        if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C00_0100) begin
            bad++; $display("FAIL br_target: got req=%b addr=%h want 1 1c000100", bus.inst_sram_req, bus.inst_sram_addr);
        end
    endtask

    task automatic test_exception();
        clr();
        bus.wb_ex    = 1'b1;
        bus.ex_entry = 32'h1C00_8000;
        #1;
        total++;
        if (bus.inst_sram_addr !== 32'h1C00_0100) begin bad++; $display("FAIL ex_addr0: got %h want 1c000100", bus.inst_sram_addr); end
        cyc();
        clr();
        #1;
        total++;
        if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C00_0100) begin
            bad++; $display("FAIL ex_addr_held: got req=%b addr=%h want 1 1c000100", bus.inst_sram_req, bus.inst_sram_addr);
        end
        bus.inst_sram_addr_ok = 1'b1;
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'hCAFE_0001;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b0 || bus.if_valid !== 1'b0) begin
            bad++; $display("FAIL ex_drop: got rg=%b v=%b want 0 0", bus.if_ready_go, bus.if_valid);
        end
        cyc();
        clr();
        #1;
        total++;
        if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C00_8000) begin
            bad++; $display("FAIL ex_target: got req=%b addr=%h want 1 1c008000", bus.inst_sram_req, bus.inst_sram_addr);
        end
    endtask

    task automatic test_both_redirects();
        clr();
        bus.inst_sram_addr_ok = 1'b1;
        bus.wb_ex             = 1'b1;
        bus.ex_entry          = 32'h1C00_A000;
        bus.id_br_taken       = 1'b1;
        bus.id_br_target      = 32'h1C00_0200;
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b0) begin bad++; $display("FAIL both_drop: got rg=%b want 0", bus.if_ready_go); end
        cyc();
        clr();
        #1;
        total++;
        if (bus.inst_sram_addr !== 32'h1C00_A000) begin bad++; $display("FAIL both_target: got %h want 1c00a000", bus.inst_sram_addr); end
    endtask

    task automatic test_wrap();
        clr();
        bus.inst_sram_addr_ok = 1'b1;
        bus.wb_ex             = 1'b1;
        bus.ex_entry          = 32'hFFFF_FFFC;
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        cyc();
        clr();
        bus.inst_sram_addr_ok = 1'b1;
        #1;
        total++;
        if (bus.inst_sram_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", bus.inst_sram_addr); end
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'h0000_0A0A;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC || bus.if_inst !== 32'h0000_0A0A) begin
            bad++; $display("FAIL wrap_data: got rg=%b pc=%h inst=%h want 1 fffffffc 00000a0a", bus.if_ready_go, bus.if_pc, bus.if_inst);
        end
        cyc();
        clr();
        #1;
        total++;
        if (bus.inst_sram_addr !== 32'd0) begin bad++; $display("FAIL wrap_next: got %h want 0", bus.inst_sram_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        clr();
        bus.inst_sram_addr_ok = 1'b1;
        cyc();
        clr();
        rst = 1'b0;
        #1;
        total++;
        if (bus.inst_sram_req !== 1'b0 || bus.if_valid !== 1'b0) begin
            bad++; $display("FAIL mid_rst: got req=%b v=%b want 0 0", bus.inst_sram_req, bus.if_valid);
        end
        cyc();
        rst = 1'b1;
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'h5555_AAAA;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b0) begin bad++; $display("FAIL mid_late_data: got rg=%b want 0", bus.if_ready_go); end
        cyc();
        clr();
        wait_req("mid");
        total++;
        if (bus.inst_sram_addr !== 32'h1C00_0000 || bus.if_ready_go !== 1'b0) begin
            bad++; $display("FAIL mid_restart: got addr=%h rg=%b want 1c000000 0", bus.inst_sram_addr, bus.if_ready_go);
        end
        bus.inst_sram_addr_ok = 1'b1;
        cyc();
        clr();
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = 32'h0000_1111;
        #1;
        total++;
        if (bus.if_ready_go !== 1'b1 || bus.if_pc !== 32'h1C00_0000 || bus.if_inst !== 32'h0000_1111) begin
            bad++; $display("FAIL mid_first: got rg=%b pc=%h inst=%h want 1 1c000000 00001111", bus.if_ready_go, bus.if_pc, bus.if_inst);
        end
        cyc();
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        total = 0;
        bad   = 0;
        test_reset();
        test_seq();
        test_hold();
        test_branch();
        test_exception();
        test_both_redirects();
        test_wrap();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller for the IF stage of the pipelined CPU. It issues requests on the instruction SRAM-like interface and tracks the single outstanding fetch. It buffers the returned instruction until ID accepts it. On an exception flush or an ID branch it redirects the PC and silently discards any stale response. It produces the `if_ready_go`, `inst_sram_req` and handshake signals consumed by the ID-stage cancel tracker.

## Interface
- `RESET_PC`, default 32'h1C00_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_ex`  in  1  exception/ertn flush from WB; highest-priority redirect.
- `ex_entry`  in  32  redirect target when `wb_ex`=1.
- `id_br_taken`  in  1  taken branch/jump resolved in ID.
- `id_br_target`  in  32  redirect target when `id_br_taken`=1 and `wb_ex`=0.
- `id_allow_in`  in  1  ID can accept an instruction this cycle.
- `inst_sram_req`  out  1  fetch request.
- `inst_sram_addr`  out  32  fetch address.
- `inst_sram_addr_ok`  in  1  address accepted.
- `inst_sram_data_ok`  in  1  read data returned.
- `inst_sram_rdata`  in  32  instruction word.
- `if_valid`  out  1  IF holds a live (non-dropped) instruction slot.
- `if_ready_go`  out  1  instruction word available this cycle.
- `if_pc`  out  32  PC of the IF instruction.
- `if_inst`  out  32  instruction word: buffered value in HOLD, `inst_sram_rdata` in WAIT_DATA.

## Operation
- FSM states: REQ, WAIT_DATA, HOLD.
- Registers: `fetch_pc`, `if_pc`, `inst_buf`, `drop`, `redir_valid`, `redir_pc`.
- Redirect: `redir = wb_ex | id_br_taken`. Target is `ex_entry` when `wb_ex`=1, otherwise `id_br_target`.
- REQ state:
  - `inst_sram_req`=1 and `inst_sram_addr`=`fetch_pc`. The address is stable until `addr_ok`.
  - On `addr_ok`: `if_pc`<=`fetch_pc`, go to WAIT_DATA.
  - On `addr_ok`, `fetch_pc` is loaded with the first applicable of: the current redirect target; `redir_pc` if `redir_valid`; otherwise `fetch_pc`+4.
  - On `addr_ok`, `drop` is set if `redir` or `redir_valid`, and `redir_valid` is cleared.
  - On `redir` without `addr_ok`: `redir_valid`<=1 and `redir_pc`<=target (a later redirect overwrites).
- WAIT_DATA state:
  - `data_ok` with `drop`=1: discard the data, clear `drop`, go to REQ.
  - `data_ok` with `drop`=0 and `id_allow_in`=1: pass through to ID, go to REQ.
  - `data_ok` with `drop`=0 and `id_allow_in`=0: `inst_buf`<=`rdata`, go to HOLD.
  - `redir` without `data_ok`: `drop`<=1 and `fetch_pc`<=target.
  - `redir` with `data_ok`: discard the data, `fetch_pc`<=target, go to REQ.
- HOLD state:
  - `id_allow_in`=1: go to REQ.
  - `redir`: discard the buffer, `fetch_pc`<=target, go to REQ.
- Output rules:
  - `if_ready_go` = (HOLD) | (WAIT_DATA & `data_ok` & !`drop`).
  - `if_valid` = (WAIT_DATA & !`drop`) | HOLD, forced to 0 in any cycle with `redir`.
- At most one request is outstanding. No new request is issued while in WAIT_DATA or HOLD.
- `wb_ex` and `id_br_taken` in the same cycle: the `wb_ex` target wins.
- Address arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state=REQ, `fetch_pc`=`RESET_PC`, `if_pc`=0, `inst_buf`=0;
  - `drop`=0, `redir_valid`=0;
  - `inst_sram_req`=0 and `if_valid`=0.
- `inst_sram_req` rises in the first cycle after `rst` deasserts.
- Reset mid-fetch abandons the outstanding request. After reset, a `data_ok` arriving outside WAIT_DATA is ignored.
- Latency:
  - `addr_ok` same cycle as `req`, `data_ok` one cycle later: `if_ready_go` is high in cycle 2.
  - The next `req` is issued in cycle 3.
- Redirect takes effect on the next edge. The target appears on `inst_sram_addr` at the next REQ, and no stale instruction ever gets `if_ready_go`=1.

## Test plan
- Reset release with `addr_ok`=`data_ok` immediate and `id_allow_in`=1 → addresses 1C000000, 1C000004, 1C000008 issued, each `if_ready_go` carrying the matching `rdata`.
- `id_allow_in`=0 for 3 cycles after `data_ok` → HOLD state, `if_inst` stable, no `req` issued; release → `req` for the next PC.
- `id_br_taken`=1 (target 1C000100) while in WAIT_DATA, `data_ok` 2 cycles later → that data dropped (`if_ready_go`=0), next address 1C000100.
- `wb_ex`=1 (`ex_entry` 1C008000) while `req` is held without `addr_ok` → address held until `addr_ok`, its data dropped, next address 1C008000.
- `wb_ex` and `id_br_taken` in the same cycle with different targets → fetch goes to `ex_entry`.
- Assert `rst`=0 while in WAIT_DATA, then send a late `data_ok` → ignored, first `req` after release is `RESET_PC`.
